// File: rtl/mdio_master.sv
// mdio_master: IEEE 802.3 clause 22 MDIO management master.
//
// Accepts single-cycle read/write requests in IDLE and serialises the frame
// PRE(32 ones, optional) / ST / OP / PHYAD / REGAD / TA / DATA onto mdc/mdio.
// Each bit spends CLKDIV cycles with mdc low, then CLKDIV cycles with mdc high.
//
// Ports:
//   wb_clk, wb_rst      clock, synchronous active-high reset
//   phy_addr, reg_addr  frame addresses, latched at accept
//   wdata, no_pre       write data / preamble suppress, latched at accept
//   rd_req, wr_req      requests, sampled only in IDLE (read wins)
//   rdata, rdata_vld    last read data, one-cycle valid pulse
//   done, busy, ta_err  completion pulse, frame in flight, turnaround error
//   mdc, mdio_o,        MDIO clock and pad control; mdio_o idles high
//   mdio_oe, mdio_i     whenever the pad is not driven
//
// Optional build macro MDIO_TA_CHECK_EN: checks the second TA bit of a read
// and flags a non-responding PHY through ta_err instead of rdata_vld.
module mdio_master #(
  parameter int CLKDIV = 100
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic [4:0]  phy_addr,
  input  logic [4:0]  reg_addr,
  input  logic [15:0] wdata,
  input  logic        no_pre,
  input  logic        rd_req,
  input  logic        wr_req,
  output logic [15:0] rdata,
  output logic        rdata_vld,
  output logic        done,
  output logic        busy,
  output logic        ta_err,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_cnt;
  logic          ph;        // current mdc phase while a frame is active
  logic [5:0]    bit_cnt;   // bit index within the current state
  logic          is_rd;
  logic [31:0]   tx_sr;     // ST OP PHYAD REGAD TA DATA, MSB shifted out first
  logic [15:0]   rx_sr;

  logic div_wrap, rise, bit_end;
  assign div_wrap = (div_cnt == DIV_LAST);
  assign rise     = !ph && div_wrap;   // edge on which mdc goes 0->1
  assign bit_end  = ph && div_wrap;    // last cycle of the high phase

`ifdef MDIO_TA_CHECK_EN
  logic ta_bad;
`endif

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    mdc       = 1'b0;
    mdio_oe   = 1'b0;
    mdio_o    = 1'b1;
    done      = 1'b0;
    rdata_vld = 1'b0;
    ta_err    = 1'b0;
    case (state_q)
      S_IDLE: if (rd_req || wr_req) state_d = no_pre ? S_HDR : S_PRE;
      S_PRE: begin
        busy = 1'b1; mdc = ph; mdio_oe = 1'b1;
        if (bit_end && bit_cnt == 6'd31) state_d = S_HDR;
      end
      S_HDR: begin
        busy = 1'b1; mdc = ph; mdio_oe = 1'b1; mdio_o = tx_sr[31];
        if (bit_end && bit_cnt == 6'd13) state_d = S_TA;
      end
      S_TA: begin
        busy = 1'b1; mdc = ph; mdio_oe = !is_rd; mdio_o = is_rd | tx_sr[31];
        if (bit_end && bit_cnt == 6'd1) state_d = S_DATA;
      end
      S_DATA: begin
        busy = 1'b1; mdc = ph; mdio_oe = !is_rd; mdio_o = is_rd | tx_sr[31];
        if (bit_end && bit_cnt == 6'd15) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
`ifdef MDIO_TA_CHECK_EN
        ta_err    = is_rd && ta_bad;
        rdata_vld = is_rd && !ta_bad;
`else
        rdata_vld = is_rd;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q <= S_IDLE;
      div_cnt <= '0;
      ph      <= 1'b0;
      bit_cnt <= '0;
      is_rd   <= 1'b0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rdata   <= '0;
`ifdef MDIO_TA_CHECK_EN
      ta_bad  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (busy) begin
        div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
        if (div_wrap) ph <= ~ph;
        if (bit_end) bit_cnt <= (state_d != state_q) ? '0 : bit_cnt + 1'b1;
        if (bit_end && state_q != S_PRE) tx_sr <= {tx_sr[30:0], 1'b0};
        if (rise && state_q == S_DATA && is_rd) rx_sr <= {rx_sr[14:0], mdio_i};
`ifdef MDIO_TA_CHECK_EN
        if (rise && state_q == S_TA && bit_cnt == 6'd1) ta_bad <= mdio_i;
`endif
        // Publish on entry to DONE so rdata is valid alongside rdata_vld.
        if (bit_end && state_d == S_DONE && is_rd) rdata <= rx_sr;
      end else begin
        div_cnt <= '0;
        ph      <= 1'b0;
        bit_cnt <= '0;
        if (state_q == S_IDLE && (rd_req || wr_req)) begin
          is_rd <= rd_req;
          tx_sr <= {2'b01, (rd_req ? 2'b10 : 2'b01), phy_addr, reg_addr, 2'b10, wdata};
`ifdef MDIO_TA_CHECK_EN
          ta_bad <= 1'b0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
module tb_mdio_master;
  logic        wb_clk = 0, wb_rst = 1;
  logic [4:0]  phy_addr = 0, reg_addr = 0;
  logic [15:0] wdata = 0;
  logic        no_pre = 0, rd_req = 0, wr_req = 0, mdio_i = 1;
  logic [15:0] rdata;
  logic        rdata_vld, done, busy, ta_err, mdc, mdio_o, mdio_oe;

  int n_cmp = 0, n_bad = 0;
  logic [15:0] last_rd = 0;

  mdio_master #(.CLKDIV(4)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .phy_addr(phy_addr), .reg_addr(reg_addr),
    .wdata(wdata), .no_pre(no_pre), .rd_req(rd_req), .wr_req(wr_req),
    .rdata(rdata), .rdata_vld(rdata_vld), .done(done), .busy(busy), .ta_err(ta_err),
    .mdc(mdc), .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i));

  always #5 wb_clk = ~wb_clk;

  // Reference frame: bit i of the frame sits at position 63-i.
  function automatic void model(input bit rd, input logic [4:0] pa, input logic [4:0] ra,
                                input logic [15:0] wd, input bit np,
                                output logic [63:0] eo, output logic [63:0] eoe);
    bit qo[$], qe[$];
    if (!np) for (int i = 0; i < 32; i++) begin qo.push_back(1); qe.push_back(1); end
    qo.push_back(0); qe.push_back(1); qo.push_back(1); qe.push_back(1);
    qo.push_back(rd); qe.push_back(1); qo.push_back(!rd); qe.push_back(1);
    for (int i = 4; i >= 0; i--) begin qo.push_back(pa[i]); qe.push_back(1); end
    for (int i = 4; i >= 0; i--) begin qo.push_back(ra[i]); qe.push_back(1); end
    if (rd) begin
      for (int i = 0; i < 18; i++) begin qo.push_back(1); qe.push_back(0); end
    end else begin
      qo.push_back(1); qe.push_back(1); qo.push_back(0); qe.push_back(1);
      for (int i = 15; i >= 0; i--) begin qo.push_back(wd[i]); qe.push_back(1); end
    end
    eo = '0; eoe = '0;
    for (int i = 0; i < qo.size(); i++) begin eo[63-i] = qo[i]; eoe[63-i] = qe[i]; end
  endfunction

  // Issues one request and plays the PHY; returns at the first non-busy cycle.
  task automatic run_frame(input bit rd, input bit wr, input logic [4:0] pa, input logic [4:0] ra,
                           input logic [15:0] wd, input bit np, input logic [15:0] pd,
                           input bit ta1, input bit midwr,
                           output int blen, output int mbad, output logic [63:0] oo,
                           output logic [63:0] ooe, output bit dn, output bit vld,
                           output bit terr, output logic [15:0] rv);
    int c, b;
    oo = '0; ooe = '0; mbad = 0;
    @(negedge wb_clk);
    phy_addr = pa; reg_addr = ra; wdata = wd; no_pre = np; rd_req = rd; wr_req = wr; mdio_i = 1;
    @(negedge wb_clk);
    rd_req = 0; wr_req = 0;
    c = 0;
    while (busy && c < 2000) begin
      if (mdc !== ((c % 8) >= 4)) mbad++;
      if (c % 8 == 0 && c / 8 < 64) begin
        oo[63 - c/8] = mdio_o; ooe[63 - c/8] = mdio_oe;
        b = c / 8 - (np ? 0 : 32);
        if (rd && b == 14) mdio_i = 1;
        else if (rd && b == 15) mdio_i = ta1;
        else if (rd && b >= 16 && b < 32) mdio_i = pd[31 - b];
      end
      if (midwr && c == 40) wr_req = 1;
      if (midwr && c == 41) wr_req = 0;
      @(negedge wb_clk); c++;
    end
    wr_req = 0; mdio_i = 1;
    blen = c; dn = done; vld = rdata_vld; terr = ta_err; rv = rdata;
  endtask

  // Counts done pulses and busy cycles over a quiet window.
  task automatic quiet(input int cyc, output int act);
    act = 0;
    repeat (cyc) begin
      @(negedge wb_clk);
      if (done || busy) act++;
    end
  endtask

  task automatic test_reset;
    wb_rst = 1;
    repeat (3) @(negedge wb_clk);
    n_cmp++;
    if ({busy, done, mdc, mdio_oe, rdata_vld, ta_err, rdata} !== 22'd0) begin
      n_bad++; $display("FAIL reset_outputs got %h want 0",
                        {busy, done, mdc, mdio_oe, rdata_vld, ta_err, rdata});
    end
    wb_rst = 0;
  endtask

  task automatic test_write_plan;
    int bl, mb; logic [63:0] oo, ooe; bit dn, vld, te; logic [15:0] rv;
    run_frame(0, 1, 5'd7, 5'd0, 16'h1140, 0, 16'h0, 0, 0, bl, mb, oo, ooe, dn, vld, te, rv);
    n_cmp++; if (bl != 512) begin n_bad++; $display("FAIL wr_busy_len got %0d want 512", bl); end
    n_cmp++;
    if (oo !== {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd7, 5'd0, 2'b10, 16'h1140}) begin
      n_bad++; $display("FAIL wr_stream got %h want %h", oo,
                        {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd7, 5'd0, 2'b10, 16'h1140});
    end
    n_cmp++; if (ooe !== {64{1'b1}}) begin n_bad++; $display("FAIL wr_oe got %h want all ones", ooe); end
    n_cmp++; if (mb != 0) begin n_bad++; $display("FAIL wr_mdc_shape got %0d bad cycles want 0", mb); end
    n_cmp++;
    if ({dn, vld, te, mdc, mdio_oe, busy} !== 6'b100000) begin
      n_bad++; $display("FAIL wr_done_cycle got %b want 100000", {dn, vld, te, mdc, mdio_oe, busy});
    end
    @(negedge wb_clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL wr_done_width got %b want 0", done); end
  endtask

  task automatic test_read_plan;
    int bl, mb; logic [63:0] oo, ooe; bit dn, vld, te; logic [15:0] rv;
    run_frame(1, 0, 5'd7, 5'd2, 16'h0, 1, 16'h796D, 0, 0, bl, mb, oo, ooe, dn, vld, te, rv);
    n_cmp++; if (bl != 256) begin n_bad++; $display("FAIL rd_busy_len got %0d want 256", bl); end
    n_cmp++;
    if (oo[63:50] !== {2'b01, 2'b10, 5'd7, 5'd2}) begin
      n_bad++; $display("FAIL rd_header got %b want %b", oo[63:50], {2'b01, 2'b10, 5'd7, 5'd2});
    end
    n_cmp++;
    if (ooe[63:32] !== {14'h3FFF, 18'h0}) begin
      n_bad++; $display("FAIL rd_oe got %h want %h", ooe[63:32], {14'h3FFF, 18'h0});
    end
    n_cmp++;
    if ({dn, vld, te, rv} !== {3'b110, 16'h796D}) begin
      n_bad++; $display("FAIL rd_result got %b %b %b %h want 1 1 0 796d", dn, vld, te, rv);
    end
    last_rd = 16'h796D;
  endtask

  task automatic test_both_req;
    int bl, mb, act; logic [63:0] oo, ooe; bit dn, vld, te; logic [15:0] rv;
    logic [15:0] pd;
    pd = 16'($urandom);
    run_frame(1, 1, 5'd3, 5'd9, 16'hABCD, 1, pd, 0, 1, bl, mb, oo, ooe, dn, vld, te, rv);
    n_cmp++; if (oo[61:60] !== 2'b10) begin n_bad++; $display("FAIL both_op got %b want 10", oo[61:60]); end
    n_cmp++;
    if ({dn, vld, rv} !== {2'b11, pd}) begin
      n_bad++; $display("FAIL both_result got %b %b %h want 1 1 %h", dn, vld, rv, pd);
    end
    last_rd = pd;
    quiet(40, act);
    n_cmp++; if (act != 0) begin n_bad++; $display("FAIL both_no_second got %0d active want 0", act); end
  endtask

  task automatic test_back_to_back;
    int bl, mb, act; logic [63:0] oo, ooe, eo, eoe; bit dn, vld, te; logic [15:0] rv;
    run_frame(0, 1, 5'd1, 5'd4, 16'h5A5A, 1, 16'h0, 0, 0, bl, mb, oo, ooe, dn, vld, te, rv);
    wr_req = 1;                      // lands in the done cycle
    @(negedge wb_clk); wr_req = 0;
    quiet(20, act);
    n_cmp++; if (act != 0) begin n_bad++; $display("FAIL done_req_ignored got %0d active want 0", act); end
    run_frame(0, 1, 5'd30, 5'd17, 16'h0F0F, 1, 16'h0, 0, 0, bl, mb, oo, ooe, dn, vld, te, rv);
    model(0, 5'd30, 5'd17, 16'h0F0F, 1, eo, eoe);
    n_cmp++;
    if (oo !== eo || ooe !== eoe || bl != 256 || !dn) begin
      n_bad++; $display("FAIL b2b_frame got %h/%h len %0d want %h/%h len 256", oo, ooe, bl, eo, eoe);
    end
  endtask

  task automatic test_mid_reset;
    int bl, mb, act; logic [63:0] oo, ooe, eo, eoe; bit dn, vld, te; logic [15:0] rv;
    @(negedge wb_clk);
    phy_addr = 5'd7; reg_addr = 5'd0; wdata = 16'h1234; no_pre = 0; wr_req = 1;
    @(negedge wb_clk); wr_req = 0;
    repeat (99) @(negedge wb_clk);
    wb_rst = 1;
    @(negedge wb_clk);
    n_cmp++;
    if ({mdc, mdio_oe, busy, done} !== 4'b0) begin
      n_bad++; $display("FAIL rst_mid got %b want 0000", {mdc, mdio_oe, busy, done});
    end
    wb_rst = 0; last_rd = 0;
    quiet(30, act);
    n_cmp++; if (act != 0) begin n_bad++; $display("FAIL rst_no_done got %0d active want 0", act); end
    run_frame(1, 0, 5'd12, 5'd5, 16'h0, 0, 16'hC3A1, 0, 0, bl, mb, oo, ooe, dn, vld, te, rv);
    model(1, 5'd12, 5'd5, 16'h0, 0, eo, eoe);
    n_cmp++;
    if (oo !== eo || ooe !== eoe || bl != 512 || {dn, vld, rv} !== {2'b11, 16'hC3A1}) begin
      n_bad++; $display("FAIL rst_then_read got %h/%h len %0d rv %h want %h/%h len 512 rv c3a1",
                        oo, ooe, bl, rv, eo, eoe);
    end
    last_rd = 16'hC3A1;
  endtask

  task automatic test_random;
    int bl, mb; logic [63:0] oo, ooe, eo, eoe; bit dn, vld, te; logic [15:0] rv;
    bit rd, np; logic [4:0] pa, ra; logic [15:0] wd, pd;
    for (int k = 0; k < 8; k++) begin
      rd = 1'($urandom); np = 1'($urandom);
      pa = 5'($urandom); ra = 5'($urandom); wd = 16'($urandom); pd = 16'($urandom);
      run_frame(rd, !rd, pa, ra, wd, np, pd, 0, 0, bl, mb, oo, ooe, dn, vld, te, rv);
      model(rd, pa, ra, wd, np, eo, eoe);
      if (rd) last_rd = pd;
      n_cmp++;
      if (oo !== eo || ooe !== eoe) begin
        n_bad++; $display("FAIL rand%0d_stream got %h/%h want %h/%h", k, oo, ooe, eo, eoe);
      end
      n_cmp++;
      if (bl != (np ? 256 : 512) || mb != 0) begin
        n_bad++; $display("FAIL rand%0d_timing got len %0d mdc_bad %0d want len %0d mdc_bad 0",
                          k, bl, mb, np ? 256 : 512);
      end
      n_cmp++;
      if ({dn, vld, te, rv} !== {1'b1, rd, 1'b0, last_rd}) begin
        n_bad++; $display("FAIL rand%0d_result got %b%b%b %h want %b%b0 %h",
                          k, dn, vld, te, rv, 1'b1, rd, last_rd);
      end
    end
  endtask

  task automatic test_ta_pull;
    int bl, mb; logic [63:0] oo, ooe; bit dn, vld, te; logic [15:0] rv;
    bit exp_err;
`ifdef MDIO_TA_CHECK_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    run_frame(1, 0, 5'd9, 5'd1, 16'h0, 1, 16'hFFFF, 1, 0, bl, mb, oo, ooe, dn, vld, te, rv);
    n_cmp++;
    if ({dn, te, vld, rv} !== {1'b1, exp_err, !exp_err, 16'hFFFF}) begin
      n_bad++; $display("FAIL ta_pull got done %b err %b vld %b rv %h want 1 %b %b ffff",
                        dn, te, vld, rv, exp_err, !exp_err);
    end
  endtask

  initial begin
    test_reset;
    test_write_plan;
    test_read_plan;
    test_both_req;
    test_back_to_back;
    test_mid_reset;
    test_random;
    test_ta_pull;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
